gorev6: RTL and testbench

Frame-level histogram-equalization engine for 8-bit grayscale images, default 320x240 = 76800 pixels. It accepts one pixel per fixed-length input slot and stores the frame internally. It then builds a histogram, a CDF and a 256-entry remap LUT, and streams the equalized frame out one pixel per fixed-length output slot. It sits between a frame-source RAM reader and a result RAM writer at the top level.

---
 rtl/gorev6.sv | 266 ++++++++++++++++++++++++++
 tb/tb_gorev6.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gorev6.sv
// Frame-level histogram equalization: store an 8-bit frame, build histogram -> CDF -> remap LUT,
// then stream the remapped frame out one pixel per output slot.
module gorev6 #(
  parameter int unsigned NPIX       = 76800,
  parameter int unsigned IN_PERIOD  = 12,
  parameter int unsigned OUT_PERIOD = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  veri_i,
  output logic [7:0]  veri_o,
  output logic        veri_al_o,
  output logic        veri_gonder_o,
  output logic        islem_bitti_o,
  output logic [5:0]  durum_oku_o,
  output logic [16:0] indis_kontrol
);

  localparam int unsigned AW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [16:0] NpixLast = 17'(NPIX - 1);
  localparam logic [16:0] NpixW    = 17'(NPIX);
  localparam logic [15:0] InLast   = 16'(IN_PERIOD - 1);
  localparam logic [15:0] OutLast  = 16'(OUT_PERIOD - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReceive = 3'd1,
    StCdf     = 3'd2,
    StLut     = 3'd3,
    StSend    = 3'd4,
    StDone    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sc_q, sc_d;
  logic [16:0] k_q, k_d;
  logic [8:0]  lv_q, lv_d;
  logic [16:0] acc_q, acc_d;
  logic [16:0] cdf_min_q, cdf_min_d;
  logic        found_q, found_d;
  logic        div_busy_q, div_busy_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [16:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [7:0]  veri_q, veri_d;

  logic [7:0]  frame_mem [NPIX];
  logic [16:0] hist_q [256];
  logic [7:0]  lut_mem [256];

  logic        frame_we;
  logic        hist_we;
  logic [7:0]  hist_waddr;
  logic [16:0] hist_wdata;
  logic        lut_we;
  logic [7:0]  lut_waddr;
  logic [7:0]  lut_wdata;

  logic [16:0] hist_rd;
  logic [16:0] hist_in;
  logic [16:0] cdf_sum;
  logic [16:0] den;
  logic [16:0] diff;
  logic [24:0] num;
  logic [17:0] rem_sh;
  logic        rem_ge;
  logic [16:0] rd_idx;
  logic [7:0]  pix_next;

  assign hist_rd = hist_q[lv_q[7:0]];
  assign hist_in = hist_q[veri_i];
  assign cdf_sum = acc_q + hist_rd;
  assign den     = NpixW - cdf_min_q;
  assign diff    = (hist_rd >= cdf_min_q) ? (hist_rd - cdf_min_q) : 17'd0;
  // diff * 255 as (diff << 8) - diff
  assign num     = {diff, 8'd0} - {8'd0, diff};
  assign rem_sh  = {rem_q, quo_q[24]};
  assign rem_ge  = (rem_sh >= {1'b0, den});

  // Next pixel to present: pixel 0 on the prefetch cycle, else k+1 during SEND
  assign rd_idx   = (state_q == StSend && k_q != NpixLast) ? (k_q + 17'd1) : 17'd0;
  assign pix_next = lut_mem[frame_mem[AW'(rd_idx)]];

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    k_d        = k_q;
    lv_d       = lv_q;
    acc_d      = acc_q;
    cdf_min_d  = cdf_min_q;
    found_d    = found_q;
    div_busy_d = div_busy_q;
    div_cnt_d  = div_cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    veri_d     = veri_q;
    frame_we   = 1'b0;
    hist_we    = 1'b0;
    hist_waddr = 8'd0;
    hist_wdata = 17'd0;
    lut_we     = 1'b0;
    lut_waddr  = 8'd0;
    lut_wdata  = 8'd0;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StReceive;
          sc_d    = 16'd0;
          k_d     = 17'd0;
        end
      end

      StReceive: begin
        if (sc_q == InLast) begin
          sc_d       = 16'd0;
          frame_we   = 1'b1;
          hist_we    = 1'b1;
          hist_waddr = veri_i;
          hist_wdata = hist_in + 17'd1;
          if (k_q == NpixLast) begin
            state_d   = StCdf;
            k_d       = 17'd0;
            lv_d      = 9'd0;
            acc_d     = 17'd0;
            cdf_min_d = 17'd0;
            found_d   = 1'b0;
          end else begin
            k_d = k_q + 17'd1;
          end
        end else begin
          sc_d = sc_q + 16'd1;
        end
      end

      StCdf: begin
        hist_we    = 1'b1;
        hist_waddr = lv_q[7:0];
        hist_wdata = cdf_sum;
        acc_d      = cdf_sum;
        if (!found_q && cdf_sum != 17'd0) begin
          found_d   = 1'b1;
          cdf_min_d = cdf_sum;
        end
        if (lv_q[7:0] == 8'd255) begin
          state_d    = StLut;
          lv_d       = 9'd0;
          div_busy_d = 1'b0;
        end else begin
          lv_d = lv_q + 9'd1;
        end
      end

      StLut: begin
        if (lv_q[8]) begin
          // All 256 entries written; prefetch pixel 0 so it is valid on SEND entry
          veri_d  = pix_next;
          state_d = StSend;
          sc_d    = 16'd0;
          k_d     = 17'd0;
        end else if (!div_busy_q) begin
          if (den == 17'd0) begin
            lut_we    = 1'b1;
            lut_waddr = lv_q[7:0];
            lut_wdata = lv_q[7:0];
            lv_d      = lv_q + 9'd1;
          end else begin
            quo_d      = num;
            rem_d      = 17'd0;
            div_cnt_d  = 5'd0;
            div_busy_d = 1'b1;
          end
        end else begin
          rem_d     = 17'(rem_ge ? (rem_sh - {1'b0, den}) : rem_sh);
          quo_d     = {quo_q[23:0], rem_ge};
          div_cnt_d = div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd24) begin
            lut_we     = 1'b1;
            lut_waddr  = lv_q[7:0];
            lut_wdata  = {quo_q[6:0], rem_ge};
            div_busy_d = 1'b0;
            lv_d       = lv_q + 9'd1;
          end
        end
      end

      StSend: begin
        if (sc_q == OutLast) begin
          sc_d = 16'd0;
          if (k_q == NpixLast) begin
            state_d = StDone;
          end else begin
            k_d    = k_q + 17'd1;
            veri_d = pix_next;
          end
        end else begin
          sc_d = sc_q + 16'd1;
        end
      end

      StDone: begin
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      sc_q       <= 16'd0;
      k_q        <= 17'd0;
      lv_q       <= 9'd0;
      acc_q      <= 17'd0;
      cdf_min_q  <= 17'd0;
      found_q    <= 1'b0;
      div_busy_q <= 1'b0;
      div_cnt_q  <= 5'd0;
      rem_q      <= 17'd0;
      quo_q      <= 25'd0;
      veri_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      k_q        <= k_d;
      lv_q       <= lv_d;
      acc_q      <= acc_d;
      cdf_min_q  <= cdf_min_d;
      found_q    <= found_d;
      div_busy_q <= div_busy_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      veri_q     <= veri_d;
    end
  end

  // Reset is the only way back to IDLE, so clearing the bins here covers every new frame
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 256; i++) begin
        hist_q[i] <= 17'd0;
      end
    end else if (hist_we) begin
      hist_q[hist_waddr] <= hist_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (frame_we) begin
      frame_mem[AW'(k_q)] <= veri_i;
    end
    if (lut_we) begin
      lut_mem[lut_waddr] <= lut_wdata;
    end
  end

  assign veri_o        = veri_q;
  assign veri_al_o     = (state_q == StIdle) || (state_q == StReceive);
  assign veri_gonder_o = (state_q == StSend);
  assign islem_bitti_o = (state_q == StSend) || (state_q == StDone);
  assign durum_oku_o   = {3'b000, state_q};
  assign indis_kontrol = (state_q == StReceive || state_q == StSend) ? k_q : 17'd0;

endmodule

// File: tb/tb_gorev6.sv
// Bench for gorev6 with a small frame: random and directed images checked against a
// histogram/CDF reference model computed directly from the equalization formula.
module tb_gorev6;
  localparam int unsigned NPIX = 16;
  localparam int unsigned INP  = 12;
  localparam int unsigned OUTP = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [7:0]  veri_i;
  logic [7:0]  veri_o;
  logic        veri_al_o;
  logic        veri_gonder_o;
  logic        islem_bitti_o;
  logic [5:0]  durum_oku_o;
  logic [16:0] indis_kontrol;

  gorev6 #(.NPIX(NPIX), .IN_PERIOD(INP), .OUT_PERIOD(OUTP)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .veri_i       (veri_i),
    .veri_o       (veri_o),
    .veri_al_o    (veri_al_o),
    .veri_gonder_o(veri_gonder_o),
    .islem_bitti_o(islem_bitti_o),
    .durum_oku_o  (durum_oku_o),
    .indis_kontrol(indis_kontrol)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  pix  [NPIX];
  logic [7:0]  expv [NPIX];
  logic [7:0]  outv [NPIX];
  logic [16:0] outi [NPIX];
  bit          stab [NPIX];
  logic [5:0]  seq  [$];
  bit          timeout, al_pre, al_post, bitti_pre, bitti_first;
  bit          done_gonder, done_bitti;
  logic [7:0]  done_veri;

  task automatic tick();
    @(posedge clk);
    #1;
    if (seq.size() == 0 || seq[seq.size()-1] != durum_oku_o) seq.push_back(durum_oku_o);
  endtask

  task automatic do_reset();
    rst_i  = 1'b0;
    en_i   = 1'b0;
    veri_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    seq.delete();
    seq.push_back(durum_oku_o);
  endtask

  // Reference: histogram, cumulative counts, first nonzero count, then the remap formula.
  task automatic build_expected();
    int hist [256];
    int cdf  [256];
    int cmin, den, run;
    for (int v = 0; v < 256; v++) hist[v] = 0;
    for (int k = 0; k < int'(NPIX); k++) hist[pix[k]]++;
    run  = 0;
    cmin = -1;
    for (int v = 0; v < 256; v++) begin
      run    = run + hist[v];
      cdf[v] = run;
      if (cmin < 0 && run > 0) cmin = run;
    end
    den = int'(NPIX) - cmin;
    for (int k = 0; k < int'(NPIX); k++) begin
      if (den == 0) expv[k] = pix[k];
      else expv[k] = 8'(((cdf[pix[k]] - cmin) * 255) / den);
    end
  endtask

  task automatic run_frame(input bit pulse);
    do_reset();
    en_i = 1'b1;
    tick();
    if (pulse) en_i = 1'b0;
    for (int k = 0; k < int'(NPIX); k++) begin
      veri_i = 8'($urandom);
      repeat (INP - 1) tick();
      veri_i = pix[k];
      if (k == int'(NPIX) - 1) al_pre = veri_al_o;
      tick();
    end
    al_post   = veri_al_o;
    en_i      = 1'b0;
    veri_i    = 8'($urandom);
    timeout   = 1'b1;
    bitti_pre = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      bitti_pre = islem_bitti_o;
      tick();
      if (veri_gonder_o) begin
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      bitti_first = islem_bitti_o;
      for (int k = 0; k < int'(NPIX); k++) begin
        if (k > 0) tick();
        outv[k] = veri_o;
        outi[k] = indis_kontrol;
        stab[k] = veri_gonder_o;
        for (int c = 1; c < int'(OUTP); c++) begin
          tick();
          if (veri_o !== outv[k] || indis_kontrol !== outi[k] || !veri_gonder_o) stab[k] = 1'b0;
        end
      end
      tick();
      done_gonder = veri_gonder_o;
      done_bitti  = islem_bitti_o;
      done_veri   = veri_o;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (durum_oku_o !== 6'd0 || veri_al_o !== 1'b1 || veri_gonder_o !== 1'b0 ||
        islem_bitti_o !== 1'b0 || veri_o !== 8'd0 || indis_kontrol !== 17'd0) begin
      failures++;
      $display("FAIL reset_values: state=%0d al=%0b gonder=%0b bitti=%0b veri=%0d idx=%0d",
               durum_oku_o, veri_al_o, veri_gonder_o, islem_bitti_o, veri_o, indis_kontrol);
    end
    en_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      veri_i = 8'($urandom);
      tick();
    end
    checks++;
    if (durum_oku_o !== 6'd1 || indis_kontrol === 17'd0) begin
      failures++;
      $display("FAIL mid_receive: state=%0d idx=%0d want state 1 idx nonzero",
               durum_oku_o, indis_kontrol);
    end
    @(posedge clk);
    #3 rst_i = 1'b0;
    #1;
    checks++;
    if (durum_oku_o !== 6'd0 || veri_al_o !== 1'b1 || veri_gonder_o !== 1'b0 ||
        islem_bitti_o !== 1'b0 || veri_o !== 8'd0 || indis_kontrol !== 17'd0) begin
      failures++;
      $display("FAIL async_reset: state=%0d al=%0b idx=%0d want 0/1/0",
               durum_oku_o, veri_al_o, indis_kontrol);
    end
    for (int k = 0; k < int'(NPIX); k++) pix[k] = 8'($urandom);
    build_expected();
    run_frame(1'b0);
    checks++;
    if (timeout) begin
      failures++;
      $display("FAIL after_reset_timeout: got timeout want output");
    end
    for (int k = 0; k < int'(NPIX); k++) begin
      checks++;
      if (outv[k] !== expv[k]) begin
        failures++;
        $display("FAIL after_reset_pix%0d: got %0d want %0d", k, outv[k], expv[k]);
      end
    end
  endtask

  task automatic test_uniform();
    for (int k = 0; k < int'(NPIX); k++) pix[k] = 8'd100;
    run_frame(1'b0);
    for (int k = 0; k < int'(NPIX); k++) begin
      checks++;
      if (timeout || outv[k] !== 8'd100) begin
        failures++;
        $display("FAIL uniform_pix%0d: got %0d want 100", k, outv[k]);
      end
    end
    checks++;
    if (seq.size() != 6) begin
      failures++;
      $display("FAIL state_seq_len: got %0d want 6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== 6'(i)) begin
          failures++;
          $display("FAIL state_seq%0d: got %0d want %0d", i, seq[i], i);
        end
      end
    end
  endtask

  task automatic test_two_level();
    for (int k = 0; k < int'(NPIX); k++) pix[k] = (k < 8) ? 8'd10 : 8'd200;
    run_frame(1'b0);
    for (int k = 0; k < int'(NPIX); k++) begin
      checks++;
      if (timeout || outv[k] !== ((k < 8) ? 8'd0 : 8'd255)) begin
        failures++;
        $display("FAIL two_level_pix%0d: got %0d want %0d", k, outv[k], (k < 8) ? 0 : 255);
      end
    end
  endtask

  task automatic test_ramp();
    for (int k = 0; k < int'(NPIX); k++) pix[k] = 8'(k);
    run_frame(1'b0);
    for (int k = 0; k < int'(NPIX); k++) begin
      checks++;
      if (timeout || outv[k] !== 8'(17 * k) || outi[k] !== 17'(k) || !stab[k]) begin
        failures++;
        $display("FAIL ramp_slot%0d: got veri=%0d idx=%0d stable=%0b want %0d/%0d/1",
                 k, outv[k], outi[k], stab[k], 17 * k, k);
      end
    end
    // Reset from DONE with a nonzero held pixel
    @(posedge clk);
    #3 rst_i = 1'b0;
    #1;
    checks++;
    if (veri_o !== 8'd0 || islem_bitti_o !== 1'b0 || durum_oku_o !== 6'd0) begin
      failures++;
      $display("FAIL reset_from_done: got veri=%0d bitti=%0b state=%0d want 0/0/0",
               veri_o, islem_bitti_o, durum_oku_o);
    end
  endtask

  task automatic test_en_pulse();
    for (int k = 0; k < int'(NPIX); k++) pix[k] = 8'($urandom);
    build_expected();
    run_frame(1'b1);
    checks++;
    if (al_pre !== 1'b1 || al_post !== 1'b0) begin
      failures++;
      $display("FAIL veri_al_edge: got pre=%0b post=%0b want 1/0", al_pre, al_post);
    end
    for (int k = 0; k < int'(NPIX); k++) begin
      checks++;
      if (timeout || outv[k] !== expv[k]) begin
        failures++;
        $display("FAIL pulse_pix%0d: got %0d want %0d", k, outv[k], expv[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < int'(NPIX); k++)
        pix[k] = (f == 1) ? 8'($urandom_range(60, 50)) : 8'($urandom);
      build_expected();
      run_frame(1'b0);
      checks++;
      if (timeout || bitti_pre !== 1'b0 || bitti_first !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_start: got timeout=%0b bitti_pre=%0b bitti_first=%0b want 0/0/1",
                 f, timeout, bitti_pre, bitti_first);
      end
      for (int k = 0; k < int'(NPIX); k++) begin
        checks++;
        if (outv[k] !== expv[k] || outi[k] !== 17'(k) || !stab[k]) begin
          failures++;
          $display("FAIL rand%0d_pix%0d: got %0d idx=%0d stable=%0b want %0d idx=%0d",
                   f, k, outv[k], outi[k], stab[k], expv[k], k);
        end
      end
      checks++;
      if (done_gonder !== 1'b0 || done_bitti !== 1'b1 || done_veri !== expv[NPIX-1]) begin
        failures++;
        $display("FAIL rand%0d_done: got gonder=%0b bitti=%0b veri=%0d want 0/1/%0d",
                 f, done_gonder, done_bitti, done_veri, expv[NPIX-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_two_level();
    test_ramp();
    test_en_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
